// File: rtl/branch_pkg.sv
// Shared encodings for the multi-cycle branch resolver: opcode, funct3 codes,
// FSM state encoding and B-type immediate extraction.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 13-bit signed branch offset; the caller sign-extends to its own XLEN.
  function automatic logic signed [12:0] b_imm(input logic [31:0] ins);
    return {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_cmp_slice.sv
// One CHUNK-bit step of a serial compare: slice equality and the carry out of
// a + ~b + cin, written without forming the unused difference.
module branch_cmp_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic             slice_eq,
  output logic             cout
);

  // a + (2^CHUNK-1-b) + cin overflows exactly when a > b, or a == b with cin set.
  assign slice_eq = (a == b);
  assign cout     = (a > b) | (slice_eq & cin);

endmodule

// File: rtl/branch_resolve_mc.sv
// Multi-cycle conditional-branch resolver: accepts a branch, compares operands
// CHUNK bits per cycle (LSB first), then presents next PC and flags until taken.
module branch_resolve_mc
  import branch_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CHUNK  = 16,
  parameter int PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] next_pc,
  output logic            taken,
  output logic            illegal,
  output logic            misaligned
);

  localparam int N  = XLEN / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((XLEN % CHUNK) != 0) begin : g_chunk_check
    $error("branch_resolve_mc: CHUNK must divide XLEN exactly");
  end

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            eq_acc_q, eq_acc_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] a_q, b_q, pc_q;
  logic signed [XLEN-1:0] imm_q;
  logic [2:0]      f3_q;

  logic            accept, illegal_req, last_slice;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic            slice_eq, slice_cout;
  logic            eq_fin, ltu, lt, cond;
  logic [XLEN-1:0] target, fallthru;
  logic            unused_rs_fields;

  assign in_ready    = rst & (state_q == ST_IDLE);
  assign accept      = in_valid & in_ready;
  assign illegal_req = (instr[6:0] != OPC_BRANCH) ||
                       (instr[14:12] == 3'b010) || (instr[14:12] == 3'b011);
  assign unused_rs_fields = ^instr[24:15];

  assign a_sl = a_q[count_q*CHUNK +: CHUNK];
  assign b_sl = b_q[count_q*CHUNK +: CHUNK];

  branch_cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (a_sl),
    .b        (b_sl),
    .cin      (carry_q),
    .slice_eq (slice_eq),
    .cout     (slice_cout)
  );

  // Resolution uses the live result of the final slice so DONE is entered directly.
  assign last_slice = (count_q == CW'(N - 1));
  assign eq_fin     = eq_acc_q & slice_eq;
  assign ltu        = ~slice_cout;
  assign lt         = (a_q[XLEN-1] != b_q[XLEN-1]) ? a_q[XLEN-1] : ltu;
  assign target     = pc_q + imm_q;
  assign fallthru   = pc_q + XLEN'(PC_INC);

  always_comb begin
    cond = 1'b0;
    case (f3_q)
      F3_BEQ:  cond = eq_fin;
      F3_BNE:  cond = ~eq_fin;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    eq_acc_d     = eq_acc_q;
    carry_d      = carry_q;
    out_valid_d  = out_valid_q;
    next_pc_d    = next_pc_q;
    taken_d      = taken_q;
    illegal_d    = illegal_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          eq_acc_d = 1'b1;
          carry_d  = 1'b1;
          count_d  = '0;
          if (illegal_req) begin
            state_d      = ST_DONE;
            out_valid_d  = 1'b1;
            illegal_d    = 1'b1;
            taken_d      = 1'b0;
            misaligned_d = 1'b0;
            next_pc_d    = pc + XLEN'(PC_INC);
          end else begin
            state_d = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          eq_acc_d = eq_fin;
          carry_d  = slice_cout;
          count_d  = count_q + 1'b1;
          if (last_slice) begin
            state_d      = ST_DONE;
            out_valid_d  = 1'b1;
            taken_d      = cond;
            illegal_d    = 1'b0;
            misaligned_d = cond & target[1];
            next_pc_d    = cond ? target : fallthru;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      eq_acc_q     <= 1'b1;
      carry_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      next_pc_q    <= '0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      eq_acc_q     <= eq_acc_d;
      carry_q      <= carry_d;
      out_valid_q  <= out_valid_d;
      next_pc_q    <= next_pc_d;
      taken_q      <= taken_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Operand capture: sampled only on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= rs1_data;
      b_q   <= rs2_data;
      pc_q  <= pc;
      f3_q  <= instr[14:12];
      imm_q <= XLEN'(b_imm(instr));
    end
  end

  assign out_valid  = out_valid_q;
  assign next_pc    = next_pc_q;
  assign taken      = taken_q;
  assign illegal    = illegal_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_branch_resolve_mc.sv
// Directed bench for branch_resolve_mc with a scoreboard of expected results.
module tb_branch_resolve_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] pc, rs1_data, rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] next_pc;
  logic        taken, illegal, misaligned;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [63:0] np;
    logic        tk;
    logic        il;
    logic        mis;
    int          lat;
  } exp_t;
  exp_t sb[$];

  branch_resolve_mc #(.XLEN(64), .CHUNK(16), .PC_INC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .next_pc    (next_pc),
    .taken      (taken),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request in the current cycle (cycle 0 = accept cycle).
  task automatic drive(input logic [31:0] ins, input logic [63:0] p, a, b);
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    instr = ins; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0;
    instr    = $urandom;
    pc       = {$urandom, $urandom};
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
  endtask

  task automatic run_req(input logic [31:0] ins, input logic [63:0] p, a, b,
                         input logic [63:0] np, input logic tk, il, mis,
                         input int lat, input int stall);
    exp_t e;
    int   cyc;
    @(negedge clk);
    drive(ins, p, a, b);
    out_ready = (stall == 0);
    e.np = np; e.tk = tk; e.il = il; e.mis = mis; e.lat = lat;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      scramble_inputs();
    end while (!out_valid && cyc < 20);
    e = sb.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    end else begin
      check("latency",    64'(cyc), 64'(e.lat));
      check("next_pc",    next_pc, e.np);
      check("taken",      {63'd0, taken}, {63'd0, e.tk});
      check("illegal",    {63'd0, illegal}, {63'd0, e.il});
      check("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
      repeat (stall) begin
        @(negedge clk);
        check("hold_out_valid", {63'd0, out_valid}, 64'd1);
        check("hold_next_pc",   next_pc, e.np);
        check("hold_taken",     {63'd0, taken}, {63'd0, e.tk});
        check("hold_in_ready",  {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("after_hs_out_valid", {63'd0, out_valid}, 64'd0);
      check("after_hs_in_ready",  {63'd0, in_ready}, 64'd1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",   {63'd0, in_ready}, 64'd0);
    check("rst_next_pc",    next_pc, 64'd0);
    check("rst_flags",      {61'd0, taken, illegal, misaligned}, 64'd0);
    rst = 1'b1;

    // BEQ equal operands, taken +8; legal latency is N+1 = 5 cycles
    run_req(32'h00000463, 64'h100, 64'd5, 64'd5, 64'h108, 1, 0, 0, 5, 0);
    // BLT signed -1 < 1 taken to pc-4; BLTU same operands not taken
    run_req(32'hFE004EE3, 64'h200, '1, 64'd1, 64'h1FC, 1, 0, 0, 5, 0);
    run_req(32'hFE006EE3, 64'h200, '1, 64'd1, 64'h204, 0, 0, 0, 5, 0);
    // BGE: -1 >= 1 is false
    run_req(32'h00005463, 64'h100, '1, 64'd1, 64'h104, 0, 0, 0, 5, 0);
    // BEQ differing only in slice 1 (bit 16): not taken
    run_req(32'h00000463, 64'h100, 64'h10000, 64'h0, 64'h104, 0, 0, 0, 5, 0);
    // BGEU: top slice decides 0x8000.. >= 0x7FFF.. unsigned
    run_req(32'h00007463, 64'h300, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
            64'h308, 1, 0, 0, 5, 0);
    // Backpressure: out_ready low for 3 extra cycles
    run_req(32'h00000463, 64'h100, 64'd5, 64'd5, 64'h108, 1, 0, 0, 5, 3);
    // Illegal funct3=010: 1 cycle latency
    run_req(32'h00002463, 64'h80, 64'd0, 64'd0, 64'h84, 0, 1, 0, 1, 0);
    // Illegal opcode
    run_req(32'h00000413, 64'h90, 64'd0, 64'd0, 64'h94, 0, 1, 0, 1, 0);
    // Misaligned taken target 0x102
    run_req(32'h00000163, 64'h100, 64'd7, 64'd7, 64'h102, 1, 0, 1, 5, 0);

    // Flush on the 2nd CMP cycle: request discarded, flags keep last values
    @(negedge clk);
    drive(32'h00000463, 64'h100, 64'd5, 64'd5);
    @(negedge clk); scramble_inputs();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_in_ready",   {63'd0, in_ready}, 64'd1);
    check("flush_misaligned", {63'd0, misaligned}, 64'd1);
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("flush_no_out_valid", 64'(seen), 64'd0);
    // BNE 3 != 4 taken
    run_req(32'h00001463, 64'h40, 64'd3, 64'd4, 64'h48, 1, 0, 0, 5, 0);

    // Reset asserted during the 3rd CMP cycle
    @(negedge clk);
    drive(32'h00000463, 64'h100, 64'd5, 64'd5);
    @(negedge clk); scramble_inputs();
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_next_pc",   next_pc, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("midrst_in_ready2", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("postrst_out_valid", {63'd0, out_valid}, 64'd0);
    // Unit still works after the abort
    run_req(32'h00000463, 64'h100, 64'd5, 64'd5, 64'h108, 1, 0, 0, 5, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
